twos_negate_seq: RTL and testbench

- Parametrised, multi-cycle two's-complement unit: pass, negate, absolute value or negative-absolute of a WIDTH-bit signed operand.
- Carry propagates CHUNK bits per cycle, LSB chunk first, so long widths close timing without a full-width ripple.
- Valid/ready handshake on input and output; sits between operand registers and the ALU result mux.

---
 rtl/twos_negate_seq_pkg.sv | 19 +
 rtl/twos_negate_seq_if.sv | 23 ++
 rtl/twos_negate_seq_neg_chunk_add.sv | 15 +
 rtl/twos_negate_seq.sv | 135 +++++++++++++
 tb/tb_twos_negate_seq.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/twos_negate_seq_pkg.sv
// rtl/twos_negate_seq_pkg.sv - mode encodings, FSM states and chunk-count helper
package twos_negate_seq_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;
   localparam logic [1:0] MODE_NABS = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/twos_negate_seq_if.sv
// rtl/twos_negate_seq_if.sv - operand/result handshake bundle for twos_negate_seq
interface twos_negate_seq_if #(
   parameter int WIDTH = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/twos_negate_seq_neg_chunk_add.sv
// rtl/twos_negate_seq_neg_chunk_add.sv - CHUNK-bit adder with operand invert, carry in and carry out
module neg_chunk_add #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic             inv_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o
);
   logic [CHUNK:0] total;

   assign total           = {1'b0, a_i ^ {CHUNK{inv_i}}} + {{CHUNK{1'b0}}, cin_i};
   assign {cout_o, sum_o} = total;
endmodule

// File: rtl/twos_negate_seq.sv
// rtl/twos_negate_seq.sv - chunked multi-cycle pass/negate/abs/neg-abs unit
// Optional NEG_SAT_EN: saturate overflowing results to the most-positive value.
import twos_negate_seq_pkg::*;

module twos_negate_seq #(
   parameter int WIDTH = 6,
   parameter int CHUNK = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   twos_negate_seq_if.slave  bus
);
   localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
   localparam int PW     = NCHUNK * CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef NEG_SAT_EN
   localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;
`endif

   state_e           state_q, state_d;
   logic [PW-1:0]    op_q, op_d;
   logic [PW-1:0]    res_q, res_d;
   logic [PW-1:0]    res_shift;
   logic [IW-1:0]    idx_q, idx_d;
   logic             inv_q, inv_d;
   logic             carry_q, carry_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;
   logic [CHUNK-1:0] sum;
   logic             cout;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             inv_sel;

   // Operand shifts down one chunk per cycle; sums enter the result from the top.
   neg_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a_i   (op_q[CHUNK-1:0]),
      .inv_i (inv_q),
      .cin_i (carry_q),
      .sum_o (sum),
      .cout_o(cout)
   );

   assign res_shift = (res_q >> CHUNK) | (PW'(sum) << (PW - CHUNK));

   always_comb begin
      inv_sel = 1'b0;
      case (bus.in_mode)
         MODE_PASS: inv_sel = 1'b0;
         MODE_NEG:  inv_sel = 1'b1;
         MODE_ABS:  inv_sel = bus.in_data[WIDTH-1];
         MODE_NABS: inv_sel = ~bus.in_data[WIDTH-1];
         default:   inv_sel = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      res_d       = res_q;
      idx_d       = idx_q;
      inv_d       = inv_q;
      carry_d     = carry_q;
      ovf_pend_d  = ovf_pend_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               op_d       = PW'(bus.in_data);
               res_d      = '0;
               idx_d      = '0;
               inv_d      = inv_sel;
               carry_d    = inv_sel;
               ovf_pend_d = (bus.in_data == MOST_NEG) &&
                            ((bus.in_mode == MODE_NEG) || (bus.in_mode == MODE_ABS));
               state_d    = BUSY;
            end
         end
         BUSY: begin
            op_d    = op_q >> CHUNK;
            res_d   = res_shift;
            carry_d = cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(NCHUNK - 1)) begin
               state_d    = DONE;
               out_data_d = res_shift[WIDTH-1:0];
               out_ovf_d  = ovf_pend_q;
`ifdef NEG_SAT_EN
               if (ovf_pend_q) out_data_d = MOST_POS;
`endif
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         res_q      <= '0;
         idx_q      <= '0;
         inv_q      <= 1'b0;
         carry_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         res_q      <= res_d;
         idx_q      <= idx_d;
         inv_q      <= inv_d;
         carry_q    <= carry_d;
         ovf_pend_q <= ovf_pend_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_twos_negate_seq.sv
// tb/tb_twos_negate_seq.sv - directed self-checking bench for twos_negate_seq (6/2 and 7/3 builds)
module tb_twos_negate_seq;
   logic clk;
   logic rst_n;
   int   checks;
   int   passed;

`ifdef NEG_SAT_EN
   localparam logic [5:0] SAT6 = 6'b011111;
   localparam logic [6:0] SAT7 = 7'h3F;
`else
   localparam logic [5:0] SAT6 = 6'b100000;
   localparam logic [6:0] SAT7 = 7'h40;
`endif

   twos_negate_seq_if #(.WIDTH(6)) if6 ();
   twos_negate_seq_if #(.WIDTH(7)) if7 ();

   twos_negate_seq #(.WIDTH(6), .CHUNK(2)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));
   twos_negate_seq #(.WIDTH(7), .CHUNK(3)) dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run6(input string tag, input logic [1:0] mode, input logic [5:0] d,
                       input logic [5:0] exp_d, input logic exp_ovf);
      int lat;
      lat = 0;
      if6.in_valid = 1'b1;
      if6.in_data  = d;
      if6.in_mode  = mode;
      @(posedge clk); #1;
      if6.in_valid = 1'b0;
      while (!if6.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, 3);
      chk({tag, " data"}, 32'(if6.out_data), 32'(exp_d));
      chk({tag, " ovf"}, 32'(if6.out_ovf), 32'(exp_ovf));
      if6.out_ready = 1'b1;
      @(posedge clk); #1;
      if6.out_ready = 1'b0;
      chk({tag, " idle in_ready"}, 32'(if6.in_ready), 1);
   endtask

   task automatic run7(input string tag, input logic [1:0] mode, input logic [6:0] d,
                       input logic [6:0] exp_d, input logic exp_ovf);
      int lat;
      lat = 0;
      if7.in_valid = 1'b1;
      if7.in_data  = d;
      if7.in_mode  = mode;
      @(posedge clk); #1;
      if7.in_valid = 1'b0;
      while (!if7.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, 3);
      chk({tag, " data"}, 32'(if7.out_data), 32'(exp_d));
      chk({tag, " ovf"}, 32'(if7.out_ovf), 32'(exp_ovf));
      if7.out_ready = 1'b1;
      @(posedge clk); #1;
      if7.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      if6.in_valid = 1'b0; if6.in_data = '0; if6.in_mode = 2'b00; if6.out_ready = 1'b0;
      if7.in_valid = 1'b0; if7.in_data = '0; if7.in_mode = 2'b00; if7.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(if6.in_ready), 1);
      chk("reset out_valid", 32'(if6.out_valid), 0);
      chk("reset out_data", 32'(if6.out_data), 0);
      chk("reset out_ovf", 32'(if6.out_ovf), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run6("neg 5",        2'b01, 6'b000101, 6'b111011, 1'b0);
      run6("abs -5",       2'b10, 6'b111011, 6'b000101, 1'b0);
      run6("abs 5",        2'b10, 6'b000101, 6'b000101, 1'b0);
      run6("nabs 5",       2'b11, 6'b000101, 6'b111011, 1'b0);
      run6("nabs -5",      2'b11, 6'b111011, 6'b111011, 1'b0);
      run6("pass 101010",  2'b00, 6'b101010, 6'b101010, 1'b0);
      run6("neg minneg",   2'b01, 6'b100000, SAT6,      1'b1);
      run6("abs minneg",   2'b10, 6'b100000, SAT6,      1'b1);
      run6("nabs minneg",  2'b11, 6'b100000, 6'b100000, 1'b0);
      run6("pass minneg",  2'b00, 6'b100000, 6'b100000, 1'b0);
      run6("neg 0",        2'b01, 6'b000000, 6'b000000, 1'b0);
      run6("neg -1",       2'b01, 6'b111111, 6'b000001, 1'b0);

      run7("w7 neg 1",     2'b01, 7'd1,  7'h7F, 1'b0);
      run7("w7 abs -59",   2'b10, 7'h45, 7'h3B, 1'b0);
      run7("w7 neg minneg",2'b01, 7'h40, SAT7,  1'b1);

      // back-pressure: result must hold while out_ready is low
      if6.in_valid = 1'b1; if6.in_data = 6'b000101; if6.in_mode = 2'b01;
      @(posedge clk); #1;
      if6.in_valid = 1'b0;
      lat = 0;
      while (!if6.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp latency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         if6.in_valid = 1'b1; if6.in_data = 6'b000001; if6.in_mode = 2'b00;
         @(posedge clk); #1;
         chk("bp out_valid", 32'(if6.out_valid), 1);
         chk("bp data", 32'(if6.out_data), 32'(6'b111011));
         chk("bp ovf", 32'(if6.out_ovf), 0);
         chk("bp in_ready", 32'(if6.in_ready), 0);
      end
      if6.in_valid  = 1'b0;
      if6.out_ready = 1'b1;
      @(posedge clk); #1;
      if6.out_ready = 1'b0;
      chk("bp release in_ready", 32'(if6.in_ready), 1);
      chk("bp release out_valid", 32'(if6.out_valid), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("bp no ghost op", 32'(if6.out_valid), 0);

      // reset in the middle of BUSY
      if6.in_valid = 1'b1; if6.in_data = 6'b000101; if6.in_mode = 2'b01;
      @(posedge clk); #1;
      if6.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst busy out_valid", 32'(if6.out_valid), 0);
      chk("rst busy out_data", 32'(if6.out_data), 0);
      chk("rst busy in_ready", 32'(if6.in_ready), 1);
      chk("rst busy out_ovf", 32'(if6.out_ovf), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run6("post-rst neg 3", 2'b01, 6'b000011, 6'b111101, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
